// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the latch write sequencer.
// Holds the state encoding, default timing and small index helpers.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, CLEAR} lws_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_GATE_CYC  = 1;
  localparam int DEF_HOLD_CYC  = 1;

  // a is always below 2*n here, so a single subtract wraps it.
  function automatic int wrap_idx(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction

  // Width of a phase counter that must reach max(a,b,c)-1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Produces a one-hot grant and its index; the pointer register lives in the caller.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     valid
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    valid     = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'(wrap_idx(int'(ptr) + k, N_REQ));
      if (req[cand]) grant_idx = cand;
    end
    grant = valid ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/latch_write_sequencer.sv
// Shares one bank of D latches between N_REQ writers: round-robin grant,
// setup -> gate -> hold sequencing so latch_d is stable around the gate pulse.
module latch_write_sequencer
  import latch_ctrl_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int GATE_CYC  = DEF_GATE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          ack,
  input  logic                      clr_req,
  output logic                      clr_ack,
  output logic [DATA_W-1:0]         latch_d,
  output logic                      latch_gate,
  output logic                      latch_reset,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(SETUP_CYC, GATE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

  lws_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             start;
  logic             ack_n;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
        end else if (arb_valid) begin
          state_n = SETUP;
          cnt_n   = '0;
          start   = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n = GATE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GATE: begin
        if (cnt == GATE_LAST) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Outputs are registered off the next state, so ack lands on the last HOLD cycle.
    ack_n = (state_n == HOLD) && (cnt_n == HOLD_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      win_oh      <= '0;
      latch_d     <= '0;
      latch_gate  <= 1'b0;
      latch_reset <= 1'b1;
      ack         <= '0;
      clr_ack     <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      latch_gate  <= (state_n == GATE);
      latch_reset <= (state_n == CLEAR);
      clr_ack     <= (state_n == CLEAR);
      busy        <= (state_n != IDLE);
      ack         <= ack_n ? win_oh : '0;
      if (start) begin
        win_oh   <= arb_grant;
        grant_id <= arb_idx;
        latch_d  <= wdata[arb_idx*DATA_W +: DATA_W];
      end
      if (ack_n) ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + IDX_W'(1);
    end
  end

endmodule
